blink_sequencer: RTL and testbench
==================================

# blink_sequencer

Controller that sequences the blinker datapath's 1-bit LED drive from queued blink commands. A command sets on-time, off-time and pulse count, with optional repeat. The block produces the LED level plus busy/done status. It sits between a command source (host register or button debouncer) and the blinker input, in the system1000 clock domain.

## Interface
- `CNT_W`, default 16: width of the on/off duration fields and the internal timer.
- `NUM_W`, default 4: width of the pulse-count field.
- `GAP_CYCLES`, default 1000: idle cycles inserted between repetitions when repeat is set; range 1..2^CNT_W-1.

Ports (name, direction, width, meaning):
- `system1000`, in, 1: the single clock; all logic is on its rising edge.
- `system1000_rstn`, in, 1: reset, synchronous, active-low.
- `cmd_valid`, in, 1: command present.
- `cmd_ready`, out, 1: block can accept a command.
- `cmd_on`, in, CNT_W: LED-on duration in cycles.
- `cmd_off`, in, CNT_W: LED-off duration in cycles.
- `cmd_count`, in, NUM_W: number of on/off pulses per burst.
- `cmd_repeat`, in, 1: repeat the burst indefinitely after a gap.
- `abort`, in, 1: cancel the current sequence.
- `led`, out, 1: LED drive to the blinker datapath.
- `busy`, out, 1: sequence in progress.
- `done`, out, 1: one-cycle pulse when a non-repeating sequence completes.

## Operation
- States: IDLE, ON, OFF, GAP.
- `cmd_ready` = (state==IDLE) && !abort. A command is accepted on a rising edge where `cmd_valid && cmd_ready`.
- At accept, the block latches on/off/count/repeat:
  - on and off values of 0 are clamped to 1.
  - A count of 0 skips to completion: no LED activity, `done` pulses, and the state stays IDLE.
- ON: `led`=1 for on cycles, then go to OFF.
- OFF: `led`=0 for off cycles, then decrement the remaining-pulse counter.
  - If pulses remain, go to ON.
  - Else if repeat is set, go to GAP.
  - Else go to IDLE and pulse `done`.
- GAP: `led`=0 for GAP_CYCLES cycles, then reload the pulse count from the latched value and go to ON.
- `abort` has top priority. In any non-IDLE state, the next state is IDLE, `led`=0 and `done`=0. The latched command is discarded.
- `busy`=1 in ON, OFF and GAP.
- All outputs are registered or decoded from the registered state; there is no input-to-output combinational path except `cmd_ready`←`abort`.
- The timer is a CNT_W-bit down-counter. It loads duration−1 on entry to a state and transitions when it reaches 0. It never wraps.

## Timing
- Reset values (while `system1000_rstn`=0 at a clock edge):
  - state=IDLE, `led`=0, `busy`=0, `done`=0, `cmd_ready`=1 (if `abort`=0).
  - Counters are cleared.
- Reset mid-sequence takes effect at the next edge, with the same result as reset.
- Latency: a command accepted at edge k gives `led`=1 from cycle k+1.
- Pulse timing:
  - The first pulse occupies cycles k+1..k+on.
  - Off time occupies the next off cycles.
  - Each pulse period is exactly on+off cycles.
- Completion:
  - `done` is high for exactly the first IDLE cycle after the last OFF cycle.
  - `cmd_ready` is high in that same cycle, so back-to-back commands lose at most that one cycle.
- Count=0 command: `done` is high in cycle k+1 and `busy` stays 0.
- `abort` sampled at edge m: `led`=0 and `busy`=0 from cycle m+1.
- `abort` together with `cmd_valid` in IDLE: the command is not accepted.

## Structure
- Package `blink_pkg` holds:
  - the state enum `blink_state_t` (IDLE, ON, OFF, GAP);
  - the default constants for CNT_W, NUM_W and GAP_CYCLES;
  - the command struct {on, off, count, repeat}.
- Sub-module `blink_timer`: a loadable CNT_W down-counter with load, enable and `zero` flag. It is instantiated once and shared across states.

## Test plan
- on=3, off=2, count=2, repeat=0:
  - `led` = 1,1,1,0,0,1,1,1,0,0 over cycles k+1..k+10.
  - `done` is high in cycle k+11 only.
  - `busy` is high in k+1..k+10.
- on=0, off=0, count=1: clamped to on=1, off=1. Expect `led` 1,0, then `done` in cycle k+3.
- count=0: no `led` activity, `done` in cycle k+1, `busy` always 0.
- on=2, off=1, count=1, repeat=1, GAP_CYCLES=4:
  - Expect the pattern 1,1,0,0,0,0,0 repeating every 7 cycles.
  - `done` is never asserted.
  - `abort` during GAP gives `busy`=0 on the next cycle.
- Abort and reset:
  - `abort` in the second ON cycle gives `led`=0 next cycle and no `done`.
  - `cmd_valid`+`abort` in IDLE: not accepted.
  - A `system1000_rstn` low pulse mid-OFF forces all outputs to their reset values at that edge.
- Back-to-back: a second command is held valid during the first command's run. It is accepted in the `done` cycle, and its first `led`=1 follows in the next cycle.

Source files
------------

// File: rtl/blink_pkg.sv
// Shared types and default constants for the LED blink sequencer.
package blink_pkg;

  localparam int CNT_W_DEF      = 16;
  localparam int NUM_W_DEF      = 4;
  localparam int GAP_CYCLES_DEF = 1000;

  // Sequencer states; IDLE is the only state in which a command is taken.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    GAP  = 2'd3
  } blink_state_t;

  // Command layout at the default widths, as presented by a host register.
  // 'repeat' is a language keyword, hence repeat_en.
  typedef struct packed {
    logic [CNT_W_DEF-1:0] on;
    logic [CNT_W_DEF-1:0] off;
    logic [NUM_W_DEF-1:0] count;
    logic                 repeat_en;
  } blink_cmd_t;

endpackage

// File: rtl/blink_timer.sv
// Loadable down-counter shared by all timed sequencer states.
// Holds at zero instead of wrapping; load wins over counting.
module blink_timer
  import blink_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic             enable,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count_r;

  // Down-counter register: synchronous clear, load, or saturating decrement.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_r <= {CNT_W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (enable && (count_r != {CNT_W{1'b0}})) begin
      count_r <= count_r - CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/blink_sequencer.sv
// Blink sequencer: turns queued on/off/count/repeat commands into the
// registered LED drive plus busy/done status for the blinker datapath.
module blink_sequencer
  import blink_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int NUM_W      = NUM_W_DEF,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
  input  logic             system1000,
  input  logic             system1000_rstn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_on,
  input  logic [CNT_W-1:0] cmd_off,
  input  logic [NUM_W-1:0] cmd_count,
  input  logic             cmd_repeat,
  input  logic             abort,
  output logic             led,
  output logic             busy,
  output logic             done
);

  // Same fields as blink_cmd_t, sized by this instance's parameters.
  typedef struct packed {
    logic [CNT_W-1:0] on;
    logic [CNT_W-1:0] off;
    logic [NUM_W-1:0] count;
    logic             repeat_en;
  } cmd_t;

  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

  blink_state_t     state_r;
  blink_state_t     next_state_s;
  cmd_t             cmd_r;
  logic [NUM_W-1:0] pulses_r;
  logic             led_r;
  logic             busy_r;
  logic             done_r;

  logic             accept_s;
  logic             pulse_dec_s;
  logic             pulse_reload_s;
  logic             discard_s;
  logic             done_s;
  logic             timer_load_s;
  logic [CNT_W-1:0] timer_val_s;
  logic             timer_zero_s;
  logic [CNT_W-1:0] on_clamp_s;
  logic [CNT_W-1:0] off_clamp_s;

  // Zero durations behave as one cycle so every state lasts at least a cycle.
  assign on_clamp_s  = (cmd_on  == {CNT_W{1'b0}}) ? CNT_W'(1) : cmd_on;
  assign off_clamp_s = (cmd_off == {CNT_W{1'b0}}) ? CNT_W'(1) : cmd_off;

  assign cmd_ready = (state_r == IDLE) && !abort;

  blink_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (system1000),
    .rstn     (system1000_rstn),
    .load     (timer_load_s),
    .enable   (state_r != IDLE),
    .load_val (timer_val_s),
    .zero     (timer_zero_s)
  );

  // Next-state, timer reload and pulse-counter control; abort overrides all.
  always_comb begin
    next_state_s   = state_r;
    accept_s       = 1'b0;
    pulse_dec_s    = 1'b0;
    pulse_reload_s = 1'b0;
    discard_s      = 1'b0;
    done_s         = 1'b0;
    timer_load_s   = 1'b0;
    timer_val_s    = {CNT_W{1'b0}};
    case (state_r)
      IDLE: begin
        if (cmd_valid && !abort) begin
          accept_s = 1'b1;
          if (cmd_count == {NUM_W{1'b0}}) begin
            done_s = 1'b1;
          end else begin
            next_state_s = ON;
            timer_load_s = 1'b1;
            timer_val_s  = on_clamp_s - CNT_W'(1);
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      ON: begin
        if (abort) begin
          next_state_s = IDLE;
          discard_s    = 1'b1;
        end else if (timer_zero_s) begin
          next_state_s = OFF;
          timer_load_s = 1'b1;
          timer_val_s  = cmd_r.off - CNT_W'(1);
        end else begin
          next_state_s = ON;
        end
      end
      OFF: begin
        if (abort) begin
          next_state_s = IDLE;
          discard_s    = 1'b1;
        end else if (timer_zero_s) begin
          if (pulses_r > NUM_W'(1)) begin
            next_state_s = ON;
            pulse_dec_s  = 1'b1;
            timer_load_s = 1'b1;
            timer_val_s  = cmd_r.on - CNT_W'(1);
          end else if (cmd_r.repeat_en) begin
            next_state_s = GAP;
            pulse_dec_s  = 1'b1;
            timer_load_s = 1'b1;
            timer_val_s  = GAP_LOAD;
          end else begin
            next_state_s = IDLE;
            pulse_dec_s  = 1'b1;
            done_s       = 1'b1;
          end
        end else begin
          next_state_s = OFF;
        end
      end
      GAP: begin
        if (abort) begin
          next_state_s = IDLE;
          discard_s    = 1'b1;
        end else if (timer_zero_s) begin
          next_state_s   = ON;
          pulse_reload_s = 1'b1;
          timer_load_s   = 1'b1;
          timer_val_s    = cmd_r.on - CNT_W'(1);
        end else begin
          next_state_s = GAP;
        end
      end
      default: begin
        next_state_s = IDLE;
        discard_s    = 1'b1;
      end
    endcase
  end

  // State, latched command, pulse counter and registered status outputs.
  always_ff @(posedge system1000) begin
    if (!system1000_rstn) begin
      state_r  <= IDLE;
      cmd_r    <= '{on: {CNT_W{1'b0}}, off: {CNT_W{1'b0}},
                    count: {NUM_W{1'b0}}, repeat_en: 1'b0};
      pulses_r <= {NUM_W{1'b0}};
      led_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r <= next_state_s;
      led_r   <= (next_state_s == ON);
      busy_r  <= (next_state_s != IDLE);
      done_r  <= done_s;
      if (accept_s) begin
        cmd_r    <= '{on: on_clamp_s, off: off_clamp_s,
                      count: cmd_count, repeat_en: cmd_repeat};
        pulses_r <= cmd_count;
      end else if (discard_s) begin
        cmd_r    <= '{on: {CNT_W{1'b0}}, off: {CNT_W{1'b0}},
                      count: {NUM_W{1'b0}}, repeat_en: 1'b0};
        pulses_r <= {NUM_W{1'b0}};
      end else if (pulse_reload_s) begin
        pulses_r <= cmd_r.count;
      end else if (pulse_dec_s) begin
        pulses_r <= pulses_r - NUM_W'(1);
      end else begin
        pulses_r <= pulses_r;
      end
    end
  end

  assign led  = led_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_blink_sequencer.sv
// Self-checking bench for blink_sequencer. A waveform model expands each
// accepted command into its per-cycle led/busy/done values; a compare process
// checks the DUT against it every cycle, and directed literal checks pin the
// model to hand-computed patterns.
module tb_blink_sequencer;

  localparam int CNT_W = 16;
  localparam int NUM_W = 4;
  localparam int GAP   = 4;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_on = 16'd0;
  logic [CNT_W-1:0] cmd_off = 16'd0;
  logic [NUM_W-1:0] cmd_count = 4'd0;
  logic             cmd_repeat = 1'b0;
  logic             abort = 1'b0;
  logic             led;
  logic             busy;
  logic             done;

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  blink_sequencer #(
    .CNT_W      (CNT_W),
    .NUM_W      (NUM_W),
    .GAP_CYCLES (GAP)
  ) dut (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_on          (cmd_on),
    .cmd_off         (cmd_off),
    .cmd_count       (cmd_count),
    .cmd_repeat      (cmd_repeat),
    .abort           (abort),
    .led             (led),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  // Expected outputs of one cycle: {led, busy, done}.
  typedef struct packed {
    logic led;
    logic busy;
    logic done;
  } exp_t;

  localparam exp_t E_ON   = 3'b110;
  localparam exp_t E_OFF  = 3'b010;
  localparam exp_t E_DONE = 3'b001;
  localparam exp_t E_IDLE = 3'b000;

  exp_t q[$];
  exp_t cur = E_IDLE;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Expand a command into its cycle-by-cycle waveform. Repeating bursts are
  // expanded far enough ahead that every test aborts them first.
  task automatic gen_burst(input int on, input int off, input int count, input logic rep);
    int reps;
    if (on == 0) on = 1;
    if (off == 0) off = 1;
    reps = rep ? 10 : 1;
    if (count == 0) begin
      q.push_back(E_DONE);
    end else begin
      for (int r = 0; r < reps; r++) begin
        for (int p = 0; p < count; p++) begin
          for (int i = 0; i < on; i++) q.push_back(E_ON);
          for (int i = 0; i < off; i++) q.push_back(E_OFF);
        end
        if (rep) begin
          for (int i = 0; i < GAP; i++) q.push_back(E_OFF);
        end else begin
          q.push_back(E_DONE);
        end
      end
    end
  endtask

  // Model: advance the expected waveform at each edge from the sampled inputs.
  always @(posedge clk) begin
    exp_t nxt;
    if (!rstn) begin
      q.delete();
    end else if (cur.busy && abort) begin
      q.delete();
    end else if (!cur.busy && cmd_valid && !abort) begin
      gen_burst(int'(cmd_on), int'(cmd_off), int'(cmd_count), cmd_repeat);
    end
    if (q.size() > 0) nxt = q.pop_front();
    else nxt = E_IDLE;
    cur <= nxt;
  end

  // Compare DUT outputs against the model in the middle of every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check1("led", led, cur.led);
      check1("busy", busy, cur.busy);
      check1("done", done, cur.done);
      check1("cmd_ready", cmd_ready, !cur.busy && !abort);
    end
  end

  task automatic send(input logic [15:0] on, input logic [15:0] off,
                      input logic [3:0] count, input logic rep);
    @(posedge clk); #2;
    cmd_valid = 1'b1; cmd_on = on; cmd_off = off; cmd_count = count; cmd_repeat = rep;
    @(posedge clk); #2;
    cmd_valid = 1'b0;
  endtask

  task automatic capture(input int n, output logic [31:0] lv,
                         output logic [31:0] dv, output logic [31:0] bv);
    lv = 32'd0; dv = 32'd0; bv = 32'd0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      lv = {lv[30:0], led};
      dv = {dv[30:0], done};
      bv = {bv[30:0], busy};
    end
  endtask

  logic [31:0] lv, dv, bv;

  initial begin
    // Reset
    rstn = 1'b0;
    @(posedge clk); #2;
    chk_en = 1'b1;
    @(negedge clk);
    check1("reset_led", led, 1'b0);
    check1("reset_busy", busy, 1'b0);
    check1("reset_done", done, 1'b0);
    check1("reset_ready", cmd_ready, 1'b1);
    @(posedge clk); #2;
    rstn = 1'b1;
    repeat (2) @(posedge clk);

    // on=3 off=2 count=2
    send(16'd3, 16'd2, 4'd2, 1'b0);
    capture(11, lv, dv, bv);
    check32("t1_led", lv, 32'b11100111000);
    check32("t1_done", dv, 32'b00000000001);
    check32("t1_busy", bv, 32'b11111111110);
    repeat (2) @(posedge clk);

    // zero durations clamp to one cycle
    send(16'd0, 16'd0, 4'd1, 1'b0);
    capture(3, lv, dv, bv);
    check32("t2_led", lv, 32'b100);
    check32("t2_done", dv, 32'b001);
    check32("t2_busy", bv, 32'b110);
    repeat (2) @(posedge clk);

    // count=0 completes immediately
    send(16'd5, 16'd5, 4'd0, 1'b0);
    capture(2, lv, dv, bv);
    check32("t3_led", lv, 32'b00);
    check32("t3_done", dv, 32'b10);
    check32("t3_busy", bv, 32'b00);
    repeat (2) @(posedge clk);

    // repeating burst, then abort during GAP
    send(16'd2, 16'd1, 4'd1, 1'b1);
    capture(14, lv, dv, bv);
    check32("t4_led", lv, 32'b11000001100000);
    check32("t4_done", dv, 32'b0);
    repeat (4) @(posedge clk);
    #2 abort = 1'b1;
    @(posedge clk); #2;
    abort = 1'b0;
    @(negedge clk);
    check1("t4_abort_busy", busy, 1'b0);
    check1("t4_abort_led", led, 1'b0);
    repeat (3) @(posedge clk);

    // abort in the second ON cycle
    send(16'd4, 16'd1, 4'd2, 1'b0);
    @(posedge clk); #2;
    abort = 1'b1;
    @(posedge clk); #2;
    abort = 1'b0;
    capture(4, lv, dv, bv);
    check32("t5_led", lv, 32'b0000);
    check32("t5_done", dv, 32'b0000);
    check32("t5_busy", bv, 32'b0000);

    // cmd_valid with abort in IDLE is refused
    @(posedge clk); #2;
    cmd_valid = 1'b1; abort = 1'b1;
    cmd_on = 16'd2; cmd_off = 16'd2; cmd_count = 4'd1; cmd_repeat = 1'b0;
    @(negedge clk);
    check1("t6_ready", cmd_ready, 1'b0);
    @(posedge clk); #2;
    cmd_valid = 1'b0; abort = 1'b0;
    @(negedge clk);
    check1("t6_busy", busy, 1'b0);
    check1("t6_led", led, 1'b0);
    repeat (2) @(posedge clk);

    // reset pulse in the middle of OFF
    send(16'd2, 16'd5, 4'd1, 1'b0);
    repeat (2) @(posedge clk);
    #2 rstn = 1'b0;
    @(posedge clk); #2;
    rstn = 1'b1;
    @(negedge clk);
    check1("t7_led", led, 1'b0);
    check1("t7_busy", busy, 1'b0);
    check1("t7_done", done, 1'b0);
    check1("t7_ready", cmd_ready, 1'b1);
    repeat (3) @(posedge clk);

    // back-to-back: second command held valid, taken in the done cycle
    @(posedge clk); #2;
    cmd_valid = 1'b1; cmd_on = 16'd2; cmd_off = 16'd1; cmd_count = 4'd1; cmd_repeat = 1'b0;
    @(posedge clk); #2;
    cmd_on = 16'd1; cmd_off = 16'd1; cmd_count = 4'd1;
    capture(7, lv, dv, bv);
    cmd_valid = 1'b0;
    check32("t8_led", lv, 32'b1100100);
    check32("t8_done", dv, 32'b0001001);
    check32("t8_busy", bv, 32'b1110110);
    repeat (4) @(posedge clk);

    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
